// File: rtl/ddr3_dfi_seq_if.sv
// Controller-side and DFI-side signal bundle for the DDR3 DFI sequencer.
// master drives requests and DFI read returns; slave is the sequencer.
interface ddr3_dfi_seq_if #(
    parameter int DDR3_WIDTH = 16,
    parameter int ADDR_BITS  = 14
);
    logic                      ctl_cke_i;
    logic                      ctl_rst_ni;
    logic                      cmd_vld_i;
    logic                      cmd_rdy_o;
    logic [2:0]                cmd_i;
    logic [2:0]                cmd_ba_i;
    logic [ADDR_BITS-1:0]      cmd_adr_i;
    logic                      wr_vld_i;
    logic                      wr_rdy_o;
    logic [2*DDR3_WIDTH/8-1:0] wr_msk_i;
    logic [2*DDR3_WIDTH-1:0]   wr_data_i;
    logic                      rd_vld_o;
    logic                      rd_lst_o;
    logic [2*DDR3_WIDTH-1:0]   rd_data_o;
    logic                      wr_err_o;
    logic                      dfi_cke_o;
    logic                      dfi_rst_no;
    logic                      dfi_cs_no;
    logic                      dfi_ras_no;
    logic                      dfi_cas_no;
    logic                      dfi_we_no;
    logic                      dfi_odt_o;
    logic [2:0]                dfi_bank_o;
    logic [ADDR_BITS-1:0]      dfi_addr_o;
    logic                      dfi_wstb_o;
    logic                      dfi_wren_o;
    logic [2*DDR3_WIDTH/8-1:0] dfi_mask_o;
    logic [2*DDR3_WIDTH-1:0]   dfi_data_o;
    logic                      dfi_rden_o;
    logic                      dfi_rvld_i;
    logic                      dfi_last_i;
    logic [2*DDR3_WIDTH-1:0]   dfi_data_i;

    modport master (
        output ctl_cke_i, ctl_rst_ni, cmd_vld_i, cmd_i, cmd_ba_i, cmd_adr_i,
        output wr_vld_i, wr_msk_i, wr_data_i, dfi_rvld_i, dfi_last_i, dfi_data_i,
        input  cmd_rdy_o, wr_rdy_o, rd_vld_o, rd_lst_o, rd_data_o, wr_err_o,
        input  dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no,
        input  dfi_odt_o, dfi_bank_o, dfi_addr_o, dfi_wstb_o, dfi_wren_o,
        input  dfi_mask_o, dfi_data_o, dfi_rden_o
    );

    modport slave (
        input  ctl_cke_i, ctl_rst_ni, cmd_vld_i, cmd_i, cmd_ba_i, cmd_adr_i,
        input  wr_vld_i, wr_msk_i, wr_data_i, dfi_rvld_i, dfi_last_i, dfi_data_i,
        output cmd_rdy_o, wr_rdy_o, rd_vld_o, rd_lst_o, rd_data_o, wr_err_o,
        output dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no,
        output dfi_odt_o, dfi_bank_o, dfi_addr_o, dfi_wstb_o, dfi_wren_o,
        output dfi_mask_o, dfi_data_o, dfi_rden_o
    );
endinterface

// File: rtl/ddr3_dfi_seq.sv
// DDR3 DFI command sequencer: turnaround timing, write/read data windows,
// write-data underflow tracking and registered read return.
module ddr3_dfi_seq #(
    parameter int DDR3_WIDTH = 16,
    parameter int ADDR_BITS  = 14,
    parameter int WR_DELAY   = 5,
    parameter int RD_DELAY   = 5,
    parameter int T_WTR      = 13,
    parameter int T_RTW      = 6
) (
    input logic          clock,
    input logic          reset_n,
    ddr3_dfi_seq_if.slave bus
);
    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_PRE  = 3'd2;
    localparam logic [2:0] CMD_RD   = 3'd3;
    localparam logic [2:0] CMD_WR   = 3'd4;
    localparam logic [2:0] CMD_REF  = 3'd5;
    localparam logic [2:0] CMD_MRS  = 3'd6;
    localparam logic [2:0] CMD_ZQCL = 3'd7;

    localparam int WP = WR_DELAY + 4;
    localparam int RP = RD_DELAY + 4;
    localparam int DW = 2 * DDR3_WIDTH;
    localparam int MW = DDR3_WIDTH / 4;

    // Loads are N-1 so a follow-on command can be accepted exactly N cycles later.
    localparam logic [4:0] CCD_LD = 5'd3;
    localparam logic [4:0] WTR_LD = 5'(T_WTR - 1);
    localparam logic [4:0] RTW_LD = 5'(T_RTW - 1);

    logic [4:0]           ccd_cnt;
    logic [4:0]           wtr_cnt;
    logic [4:0]           rtw_cnt;
    logic [WP-1:0]        wr_pipe;
    logic [RP-1:0]        rd_pipe;
    logic                 is_rd;
    logic                 is_wr;
    logic                 cmd_rdy;
    logic                 accept;
    logic [2:0]           rcw;
    logic                 cs_n;
    logic [2:0]           rcw_q;
    logic [2:0]           bank_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 cke_q;
    logic                 rstn_q;
    logic [MW-1:0]        mask_q;
    logic [DW-1:0]        data_q;
    logic                 wr_err_q;
    logic                 rvld_q;
    logic                 rlst_q;
    logic [DW-1:0]        rdata_q;
    logic                 wr_rdy;

    assign is_rd = (bus.cmd_i == CMD_RD);
    assign is_wr = (bus.cmd_i == CMD_WR);

    always_comb begin
        cmd_rdy = 1'b1;
        if (is_rd)
            cmd_rdy = (ccd_cnt == 5'd0) && (wtr_cnt == 5'd0);
        else if (is_wr)
            cmd_rdy = (ccd_cnt == 5'd0) && (rtw_cnt == 5'd0);
        if (!reset_n)
            cmd_rdy = 1'b0;
    end

    assign accept = bus.cmd_vld_i && cmd_rdy;

    always_comb begin
        rcw = 3'b111;
        unique case (bus.cmd_i)
            CMD_NOP:  rcw = 3'b111;
            CMD_ACT:  rcw = 3'b011;
            CMD_PRE:  rcw = 3'b010;
            CMD_RD:   rcw = 3'b101;
            CMD_WR:   rcw = 3'b100;
            CMD_REF:  rcw = 3'b001;
            CMD_MRS:  rcw = 3'b000;
            CMD_ZQCL: rcw = 3'b110;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_n   <= 1'b1;
            rcw_q  <= 3'b111;
            bank_q <= '0;
            addr_q <= '0;
            cke_q  <= 1'b0;
            rstn_q <= 1'b0;
        end else begin
            cs_n   <= 1'b0;
            cke_q  <= bus.ctl_cke_i;
            rstn_q <= bus.ctl_rst_ni;
            if (accept) begin
                rcw_q  <= rcw;
                bank_q <= bus.cmd_ba_i;
                addr_q <= bus.cmd_adr_i;
            end else begin
                rcw_q  <= 3'b111;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
        end else begin
            if (accept && (is_rd || is_wr))
                ccd_cnt <= CCD_LD;
            else if (ccd_cnt != 5'd0)
                ccd_cnt <= ccd_cnt - 5'd1;
            if (accept && is_wr)
                wtr_cnt <= WTR_LD;
            else if (wtr_cnt != 5'd0)
                wtr_cnt <= wtr_cnt - 5'd1;
            if (accept && is_rd)
                rtw_cnt <= RTW_LD;
            else if (rtw_cnt != 5'd0)
                rtw_cnt <= rtw_cnt - 5'd1;
        end
    end

    // Bit k is set k cycles after the command reaches the DFI pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_pipe <= '0;
            rd_pipe <= '0;
        end else begin
            wr_pipe <= {wr_pipe[WP-2:0], accept && is_wr};
            rd_pipe <= {rd_pipe[RP-2:0], accept && is_rd};
        end
    end

    assign wr_rdy = |wr_pipe[WR_DELAY-1 +: 4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_q   <= '0;
            data_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mask_q <= '0;
            if (wr_rdy && bus.wr_vld_i) begin
                mask_q <= bus.wr_msk_i;
                data_q <= bus.wr_data_i;
            end
            if (wr_rdy && !bus.wr_vld_i)
                wr_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvld_q  <= 1'b0;
            rlst_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rvld_q  <= bus.dfi_rvld_i;
            rlst_q  <= bus.dfi_last_i;
            rdata_q <= bus.dfi_data_i;
        end
    end

    assign bus.cmd_rdy_o  = cmd_rdy;
    assign bus.wr_rdy_o   = wr_rdy;
    assign bus.wr_err_o   = wr_err_q;
    assign bus.rd_vld_o   = rvld_q;
    assign bus.rd_lst_o   = rlst_q;
    assign bus.rd_data_o  = rdata_q;
    assign bus.dfi_cke_o  = cke_q;
    assign bus.dfi_rst_no = rstn_q;
    assign bus.dfi_cs_no  = cs_n;
    assign bus.dfi_ras_no = rcw_q[2];
    assign bus.dfi_cas_no = rcw_q[1];
    assign bus.dfi_we_no  = rcw_q[0];
    assign bus.dfi_bank_o = bank_q;
    assign bus.dfi_addr_o = addr_q;
    assign bus.dfi_wstb_o = |wr_pipe[WR_DELAY +: 4];
    assign bus.dfi_odt_o  = |wr_pipe[WR_DELAY +: 4];
    assign bus.dfi_wren_o = |wr_pipe[WR_DELAY-1 +: 5];
    assign bus.dfi_mask_o = mask_q;
    assign bus.dfi_data_o = data_q;
    assign bus.dfi_rden_o = |rd_pipe[RD_DELAY +: 4];
endmodule

// File: tb/tb_ddr3_dfi_seq.sv
// Scoreboard bench for ddr3_dfi_seq: issue-time expectations in queues,
// a negedge monitor pops them as the DFI outputs present activity.
module tb_ddr3_dfi_seq;
    localparam int NB = 20;

    typedef struct {
        int         c;
        logic [2:0] rcw;
        logic [2:0] ba;
        logic [13:0] adr;
    } cmd_e;

    typedef struct {
        int          c;
        logic [3:0]  m;
        logic [31:0] d;
    } wb_e;

    typedef struct {
        int          c;
        logic        l;
        logic [31:0] d;
    } rv_e;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nb = 0;
    int   bi = 0;
    logic [31:0] last_d = '0;

    cmd_e q_cmd[$];
    wb_e  q_wb[$];
    rv_e  q_rv[$];
    int   q_wren[$];
    int   q_wrdy[$];
    int   q_rden[$];

    logic        wvld[NB];
    logic [3:0]  wmsk[NB];
    logic [31:0] wdat[NB];

    ddr3_dfi_seq_if #(.DDR3_WIDTH(16), .ADDR_BITS(14)) bus();

    ddr3_dfi_seq #(
        .DDR3_WIDTH(16), .ADDR_BITS(14), .WR_DELAY(5),
        .RD_DELAY(5), .T_WTR(13), .T_RTW(6)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got activity expected none (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [2:0] enc(logic [2:0] c);
        case (c)
            3'd1:    return 3'b011;
            3'd2:    return 3'b010;
            3'd3:    return 3'b101;
            3'd4:    return 3'b100;
            3'd5:    return 3'b001;
            3'd6:    return 3'b000;
            3'd7:    return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic void push_lvl_wren(int c);
        if (q_wren.size() == 0 || q_wren[$] != c) q_wren.push_back(c);
    endfunction

    function automatic void push_lvl_wrdy(int c);
        if (q_wrdy.size() == 0 || q_wrdy[$] != c) q_wrdy.push_back(c);
    endfunction

    task automatic issue(input logic [2:0] c, input logic [2:0] ba,
                         input logic [13:0] adr, output int acc);
        bit   done;
        int   t;
        cmd_e ce;
        wb_e  wb;
        done = 0;
        acc = -1;
        bus.cmd_vld_i = 1'b1;
        bus.cmd_i     = c;
        bus.cmd_ba_i  = ba;
        bus.cmd_adr_i = adr;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clock);
            if (bus.cmd_rdy_o) begin
                acc  = cyc;
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        bus.cmd_vld_i = 1'b0;
        bus.cmd_i     = 3'd0;
        if (!done) begin
            unexp("cmd_accept_timeout");
        end else begin
            t = acc + 1;
            if (c != 3'd0) begin
                ce.c = t; ce.rcw = enc(c); ce.ba = ba; ce.adr = adr;
                q_cmd.push_back(ce);
            end
            if (c == 3'd4) begin
                for (int k = 4; k <= 8; k++) push_lvl_wren(t + k);
                for (int k = 4; k <= 7; k++) push_lvl_wrdy(t + k);
                for (int k = 0; k < 4; k++) begin
                    wb.c = t + 5 + k;
                    wb.m = wvld[nb] ? wmsk[nb] : 4'h0;
                    if (wvld[nb]) last_d = wdat[nb];
                    wb.d = last_d;
                    q_wb.push_back(wb);
                    nb++;
                end
            end
            if (c == 3'd3)
                for (int k = 5; k <= 8; k++) q_rden.push_back(t + k);
        end
    endtask

    task automatic rd_echo(input logic [31:0] base);
        rv_e re;
        for (int j = 0; j < 4; j++) begin
            bus.dfi_rvld_i = 1'b1;
            bus.dfi_last_i = (j == 3);
            bus.dfi_data_i = base + 32'(j * 17);
            re.c = cyc + 1; re.l = (j == 3); re.d = base + 32'(j * 17);
            q_rv.push_back(re);
            @(posedge clock); #1;
            bus.dfi_rvld_i = 1'b0;
            bus.dfi_last_i = 1'b0;
            bus.dfi_data_i = 32'hDEAD_0000;
            @(posedge clock); #1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_reset(string p);
        chk({p, "_cmd"}, 64'({bus.dfi_cs_no, bus.dfi_ras_no, bus.dfi_cas_no, bus.dfi_we_no}), 64'hF);
        chk({p, "_cke_rst"}, 64'({bus.dfi_cke_o, bus.dfi_rst_no}), 64'h0);
        chk({p, "_bank_addr"}, 64'({bus.dfi_bank_o, bus.dfi_addr_o}), 64'h0);
        chk({p, "_mask_data"}, 64'({bus.dfi_mask_o, bus.dfi_data_o}), 64'h0);
        chk({p, "_strobes"}, 64'({bus.dfi_wstb_o, bus.dfi_wren_o, bus.dfi_odt_o, bus.dfi_rden_o}), 64'h0);
        chk({p, "_rdy"}, 64'({bus.cmd_rdy_o, bus.wr_rdy_o}), 64'h0);
        chk({p, "_rd_err"}, 64'({bus.rd_vld_o, bus.rd_lst_o, bus.wr_err_o}), 64'h0);
    endtask

    // Write-data source: advances one table entry per wr_rdy beat.
    initial begin
        bus.wr_vld_i  = 1'b0;
        bus.wr_msk_i  = '0;
        bus.wr_data_i = '0;
        forever begin
            @(negedge clock);
            if (reset_n && bus.wr_rdy_o && bi < NB - 1) bi++;
            @(posedge clock);
            #1;
            bus.wr_vld_i  = wvld[bi];
            bus.wr_msk_i  = wmsk[bi];
            bus.wr_data_i = wdat[bi];
        end
    end

    always @(negedge clock) begin : mon
        cmd_e ce;
        wb_e  wb;
        rv_e  re;
        if (reset_n) begin
            if (!bus.dfi_cs_no && {bus.dfi_ras_no, bus.dfi_cas_no, bus.dfi_we_no} != 3'b111) begin
                if (q_cmd.size() == 0) unexp("cmd_unexpected");
                else begin
                    ce = q_cmd.pop_front();
                    chk("cmd_cycle", 64'(cyc), 64'(ce.c));
                    chk("cmd_rcw", 64'({bus.dfi_ras_no, bus.dfi_cas_no, bus.dfi_we_no}), 64'(ce.rcw));
                    chk("cmd_bank", 64'(bus.dfi_bank_o), 64'(ce.ba));
                    chk("cmd_addr", 64'(bus.dfi_addr_o), 64'(ce.adr));
                end
            end
            if (bus.dfi_wstb_o) begin
                if (q_wb.size() == 0) unexp("wstb_unexpected");
                else begin
                    wb = q_wb.pop_front();
                    chk("wstb_cycle", 64'(cyc), 64'(wb.c));
                    chk("wr_mask", 64'(bus.dfi_mask_o), 64'(wb.m));
                    chk("wr_data", 64'(bus.dfi_data_o), 64'(wb.d));
                    chk("odt", 64'(bus.dfi_odt_o), 64'h1);
                end
            end else begin
                if (bus.dfi_odt_o) unexp("odt_unexpected");
                if (bus.dfi_mask_o != '0) unexp("mask_outside_window");
            end
            if (bus.dfi_wren_o) begin
                if (q_wren.size() == 0) unexp("wren_unexpected");
                else chk("wren_cycle", 64'(cyc), 64'(q_wren.pop_front()));
            end
            if (bus.wr_rdy_o) begin
                if (q_wrdy.size() == 0) unexp("wr_rdy_unexpected");
                else chk("wr_rdy_cycle", 64'(cyc), 64'(q_wrdy.pop_front()));
            end
            if (bus.dfi_rden_o) begin
                if (q_rden.size() == 0) unexp("rden_unexpected");
                else chk("rden_cycle", 64'(cyc), 64'(q_rden.pop_front()));
            end
            if (bus.rd_vld_o) begin
                if (q_rv.size() == 0) unexp("rd_vld_unexpected");
                else begin
                    re = q_rv.pop_front();
                    chk("rd_vld_cycle", 64'(cyc), 64'(re.c));
                    chk("rd_lst", 64'(bus.rd_lst_o), 64'(re.l));
                    chk("rd_data", 64'(bus.rd_data_o), 64'(re.d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, w1, w2, tmp;
        bit seen;
        for (int i = 0; i < NB; i++) begin
            wvld[i] = 1'b1;
            wmsk[i] = 4'((i % 15) + 1);
            wdat[i] = 32'hA500_0000 + 32'(i * 32'h0001_0203);
        end
        wvld[14] = 1'b0;
        bus.ctl_cke_i  = 1'b0;
        bus.ctl_rst_ni = 1'b0;
        bus.cmd_vld_i  = 1'b0;
        bus.cmd_i      = 3'd0;
        bus.cmd_ba_i   = 3'd0;
        bus.cmd_adr_i  = '0;
        bus.dfi_rvld_i = 1'b0;
        bus.dfi_last_i = 1'b0;
        bus.dfi_data_i = '0;

        repeat (3) @(negedge clock);
        check_reset("rst");
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(2);

        bus.ctl_cke_i  = 1'b1;
        bus.ctl_rst_ni = 1'b1;
        @(negedge clock);
        chk("cke_latency_hold", 64'({bus.dfi_cke_o, bus.dfi_rst_no}), 64'h0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("cke_latency_1", 64'({bus.dfi_cke_o, bus.dfi_rst_no}), 64'h3);
        @(posedge clock); #1;

        issue(3'd1, 3'd1, 14'h0123, a0);
        issue(3'd4, 3'd1, 14'h0040, a1);
        chk("act_wr_b2b", 64'(a1 - a0), 64'd1);
        idle(14);
        chk("wr_err_clean", 64'(bus.wr_err_o), 64'h0);

        issue(3'd4, 3'd2, 14'h0080, a0);
        issue(3'd3, 3'd2, 14'h0080, a2);
        chk("wtr_gap", 64'(a2 - a0), 64'd13);
        rd_echo(32'h1000_0000);

        issue(3'd4, 3'd3, 14'h0100, w1);
        issue(3'd4, 3'd3, 14'h0104, w2);
        chk("wr_wr_gap", 64'(w2 - w1), 64'd4);
        idle(14);
        chk("wr_err_sticky", 64'(bus.wr_err_o), 64'h1);

        issue(3'd2, 3'd4, 14'h0400, tmp);
        issue(3'd5, 3'd0, 14'h0000, tmp);
        issue(3'd6, 3'd3, 14'h01A5, tmp);
        issue(3'd7, 3'd0, 14'h0400, tmp);
        issue(3'd0, 3'd5, 14'h3FFF, tmp);
        idle(2);

        issue(3'd3, 3'd6, 14'h2ABC, a0);
        rd_echo(32'h2000_0000);
        idle(4);
        chk("wr_err_still_set", 64'(bus.wr_err_o), 64'h1);

        issue(3'd4, 3'd7, 14'h0200, a0);
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge clock);
            if (bus.dfi_wstb_o) seen = 1;
        end
        if (!seen) unexp("midrst_wstb_timeout");
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        q_cmd.delete();
        q_wb.delete();
        q_wren.delete();
        q_wrdy.delete();
        q_rden.delete();
        q_rv.delete();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        idle(20);
        chk("wr_err_after_rst", 64'(bus.wr_err_o), 64'h0);

        chk("left_cmd", 64'(q_cmd.size()), 64'd0);
        chk("left_wstb", 64'(q_wb.size()), 64'd0);
        chk("left_wren", 64'(q_wren.size()), 64'd0);
        chk("left_wrdy", 64'(q_wrdy.size()), 64'd0);
        chk("left_rden", 64'(q_rden.size()), 64'd0);
        chk("left_rvld", 64'(q_rv.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddr3_dfi_seq.md
DDR3_DFI_SEQ -- requirements
Module: ddr3_dfi_seq

Interface
REQ-001 SHALL have parameter DDR3_WIDTH, default 16: DDR3 DQ width; DFI data width is 2*DDR3_WIDTH and DFI mask width is DDR3_WIDTH/4.
REQ-002 SHALL have parameter ADDR_BITS, default 14: DDR3 row/column address width.
REQ-003 SHALL have parameter WR_DELAY, default 5, range 2..15: cycles from a DFI WR command to the first dfi_wstb_o cycle.
REQ-004 SHALL have parameter RD_DELAY, default 5, range 1..15: cycles from a DFI RD command to the first dfi_rden_o cycle.
REQ-005 SHALL have parameters T_WTR, default 13, and T_RTW, default 6: minimum cycles from WR to RD, and from RD to WR.
REQ-006 SHALL have the following ports:
- clock, in, 1: the single clock; all logic in this block is on posedge.
- reset_n, in, 1: asynchronous reset, active-low; deassertion is synchronised externally.
- ctl_cke_i, in, 1: CKE request.
- ctl_rst_ni, in, 1: DDR3 RESET# request.
- cmd_vld_i / cmd_rdy_o, in / out, 1 / 1: command handshake.
- cmd_i, in, 3: command code: 0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR, 5 REF, 6 MRS, 7 ZQCL.
- cmd_ba_i, in, 3: bank address.
- cmd_adr_i, in, ADDR_BITS: address.
- wr_vld_i / wr_rdy_o, in / out, 1 / 1: write-data handshake.
- wr_msk_i, in, 2*DDR3_WIDTH/8: byte-enables; 1 means write the byte.
- wr_data_i, in, 2*DDR3_WIDTH: write data.
- rd_vld_o, out, 1: read data valid.
- rd_lst_o, out, 1: last beat of a read burst.
- rd_data_o, out, 2*DDR3_WIDTH: read data.
- wr_err_o, out, 1: sticky write-data underflow flag.
- dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o, out, 1 each: DFI command and control.
- dfi_bank_o, out, 3: DFI bank address.
- dfi_addr_o, out, ADDR_BITS: DFI address.
- dfi_wstb_o, out, 1: write-data strobe/enable.
- dfi_wren_o, out, 1: write window including the 1-cycle DQS preamble.
- dfi_mask_o, out, 2*DDR3_WIDTH/8: DFI byte-enables, active-high.
- dfi_data_o, out, 2*DDR3_WIDTH: DFI write data.
- dfi_rden_i... correction: dfi_rden_o, out, 1: read-capture enable.
- dfi_rvld_i, dfi_last_i, in, 1 each: DFI read valid and last.
- dfi_data_i, in, 2*DDR3_WIDTH: DFI read data.

Function
REQ-007 SHALL accept a command on clock edges where cmd_vld_i and cmd_rdy_o are both high, and SHALL drive it on the DFI command outputs in the next cycle only; all other cycles SHALL drive NOP (cs_n=0, ras_n=cas_n=we_n=1).
REQ-008 SHALL encode ras_n/cas_n/we_n as: ACT 011, PRE 010, RD 101, WR 100, REF 001, MRS 000, ZQCL 110; cmd_i=0 SHALL be accepted and issue NOP.
REQ-009 SHALL register ctl_cke_i and ctl_rst_ni to dfi_cke_o and dfi_rst_no with 1-cycle latency, independent of the command handshake.
REQ-010 SHALL maintain down-counters ccd_cnt (4 cycles), wtr_cnt (T_WTR) and rtw_cnt (T_RTW), each loaded on accepting the matching command and saturating at 0.
REQ-011 cmd_rdy_o SHALL be: RD = (ccd_cnt==0 && wtr_cnt==0); WR = (ccd_cnt==0 && rtw_cnt==0); all other codes = 1 while reset_n is high.
REQ-012 SHALL use an FSM per datapath direction, with states IDLE, WAIT (delay count) and BURST (4 beats); shift-register scheduling of the same cycles is equivalent and also acceptable.
REQ-013 For a WR command issued on the DFI in cycle T:
- dfi_wren_o SHALL be high for T+WR_DELAY-1 .. T+WR_DELAY+3.
- dfi_wstb_o and dfi_odt_o SHALL be high for T+WR_DELAY .. T+WR_DELAY+3.
REQ-014 wr_rdy_o SHALL be high in the cycle before each dfi_wstb_o cycle (4 beats per WR); an accepted beat SHALL appear on dfi_data_o/dfi_mask_o in the following cycle.
REQ-015 If wr_vld_i is low when wr_rdy_o is high, the block SHALL drive dfi_mask_o all-zero for that beat and SHALL set wr_err_o, which stays set until reset.
REQ-016 Back-to-back WRs spaced 4 cycles apart SHALL produce a continuous dfi_wstb_o; the preamble cycle overlaps the previous burst and dfi_wren_o stays high throughout.
REQ-017 For an RD command issued on the DFI in cycle T, dfi_rden_o SHALL be high for T+RD_DELAY .. T+RD_DELAY+3.
REQ-018 SHALL register dfi_rvld_i, dfi_last_i and dfi_data_i to rd_vld_o, rd_lst_o and rd_data_o with 1-cycle latency; the read path has no backpressure.
REQ-019 Outputs outside active windows SHALL hold: wstb, wren, odt and rden at 0; mask at 0; data at its last value.

Reset
REQ-020 While reset_n is low, all state SHALL clear asynchronously: dfi_cs_no=1, ras/cas/we_n=1, dfi_cke_o=0, dfi_rst_no=0, bank/addr/mask/data=0, all strobes=0, cmd_rdy_o=0, wr_rdy_o=0, rd_vld_o=0, rd_lst_o=0, wr_err_o=0, counters=0.
REQ-021 Reset during a pending or active burst SHALL abandon that burst; no strobe SHALL assert after reset is released unless a new command is accepted.

Verification
REQ-022 Scenario: ACT then WR accepted in cycles 0 and 1, WR_DELAY=5 -> DFI WR in cycle 2; dfi_wren_o high 6..10; dfi_wstb_o high 7..10; wr_rdy_o high 6..9.
REQ-023 Scenario: RD accepted in cycle 0, RD_DELAY=5 -> dfi_rden_o high 6..9; dfi_rvld_i pulses are echoed on rd_vld_o one cycle later.
REQ-024 Scenario: WR in cycle 0 with RD presented from cycle 1 -> cmd_rdy_o low until wtr_cnt reaches 0; the RD is accepted in cycle 13.
REQ-025 Scenario: two WRs 4 cycles apart with wr_vld_i held low on beat 6 -> dfi_wstb_o continuous for 8 cycles; dfi_mask_o=0 on beat 6; wr_err_o=1 thereafter.
REQ-026 Scenario: reset_n driven low mid-burst -> all outputs take their REQ-020 values immediately with no clock edge; no strobe appears after release.
